mem_port_arbiter: RTL

- Shares one single-port, synchronous-read memory between NUM_CLIENTS requesters, e.g. the UART command controller and a debug/pattern engine.
- Round-robin arbitration with a per-client req/gnt handshake.
- Latches the winning request, drives the memory port, and returns read data with a per-client valid pulse.
- Sits between the client controllers and the `memory` instance; owns that instance's we/addr/din.

---
 rtl/mem_arb_pkg.sv | 16 +
 rtl/mem_port_arbiter_rr_arbiter.sv | 61 ++++++
 rtl/mem_port_arbiter.sv | 129 ++++++++++++
 3 files changed

// File: rtl/mem_arb_pkg.sv
// Shared definitions for the memory-port arbiter: FSM state encoding and
// default sizing for the client/memory interface.
package mem_arb_pkg;

    // FSM state codes; these values are also shown on state_leds.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        RESP  = 2'd2
    } arb_state_t;

    localparam int DEF_NUM_CLIENTS = 2;
    localparam int DEF_MEM_WIDTH   = 8;
    localparam int DEF_MEM_DEPTH   = 256;

endpackage : mem_arb_pkg

// File: rtl/mem_port_arbiter_rr_arbiter.sv
// rr_arbiter: combinational winner select for the memory-port arbiter.
// Default build: round-robin starting at rr_ptr, wrapping modulo NUM_CLIENTS.
// With MEM_ARB_FIXED_PRIO_EN defined: fixed priority, lowest index wins and
// rr_ptr is ignored.
module rr_arbiter #(
    parameter  int NUM_CLIENTS = 2,
    localparam int IDX_W       = $clog2(NUM_CLIENTS)
) (
    input  logic [NUM_CLIENTS-1:0] req,
    input  logic [IDX_W-1:0]       rr_ptr,
    output logic [NUM_CLIENTS-1:0] gnt_onehot,
    output logic [IDX_W-1:0]       gnt_idx,
    output logic                   gnt_any
);

    // cand_idx[k] is the client examined at search position k.
    logic [IDX_W-1:0]       cand_idx [NUM_CLIENTS];
    logic [NUM_CLIENTS-1:0] req_rot;

`ifdef MEM_ARB_FIXED_PRIO_EN
    // The pointer has no meaning in the fixed-priority build.
    logic unused_rr_ptr;
    assign unused_rr_ptr = ^rr_ptr;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_CLIENTS; gi++) begin : g_cand
            assign cand_idx[gi] = IDX_W'(gi);
            assign req_rot[gi]  = req[gi];
        end
    endgenerate
`else
    genvar gi;
    generate
        for (gi = 0; gi < NUM_CLIENTS; gi++) begin : g_cand
            // rr_ptr < N and gi < N, so one conditional subtract wraps the sum.
            logic [IDX_W:0] sum;
            assign sum          = {1'b0, rr_ptr} + (IDX_W+1)'(gi);
            assign cand_idx[gi] = (sum >= (IDX_W+1)'(NUM_CLIENTS))
                                  ? IDX_W'(sum - (IDX_W+1)'(NUM_CLIENTS))
                                  : sum[IDX_W-1:0];
            assign req_rot[gi]  = req[cand_idx[gi]];
        end
    endgenerate
`endif

    // First requesting client in search order wins; scanning downwards lets
    // the lowest search position overwrite any later one.
    always_comb begin
        gnt_idx    = '0;
        gnt_any    = 1'b0;
        for (int k = NUM_CLIENTS - 1; k >= 0; k--) begin
            if (req_rot[k]) begin
                gnt_idx = cand_idx[k];
                gnt_any = 1'b1;
            end
        end
        gnt_onehot = gnt_any ? (NUM_CLIENTS'(1) << gnt_idx) : '0;
    end

endmodule : rr_arbiter

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one single-port synchronous-read memory between
// NUM_CLIENTS requesters. IDLE picks a winner and latches its request,
// ISSUE drives the memory port and pulses gnt, RESP returns read data.
// Build option: MEM_ARB_FIXED_PRIO_EN selects fixed priority (lowest index
// wins) instead of round-robin; all timing is otherwise identical.
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter  int NUM_CLIENTS = DEF_NUM_CLIENTS,
    parameter  int MEM_WIDTH   = DEF_MEM_WIDTH,
    parameter  int MEM_DEPTH   = DEF_MEM_DEPTH,
    localparam int ADDR_WIDTH  = $clog2(MEM_DEPTH)
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic [NUM_CLIENTS-1:0]            req,
    input  logic [NUM_CLIENTS-1:0]            req_we,
    input  logic [NUM_CLIENTS*ADDR_WIDTH-1:0] req_addr,
    input  logic [NUM_CLIENTS*MEM_WIDTH-1:0]  req_din,
    output logic [NUM_CLIENTS-1:0]            gnt,
    output logic [NUM_CLIENTS-1:0]            rd_valid,
    output logic [MEM_WIDTH-1:0]              rd_data,
    output logic                              mem_we,
    output logic [ADDR_WIDTH-1:0]             mem_addr,
    output logic [MEM_WIDTH-1:0]              mem_din,
    input  logic [MEM_WIDTH-1:0]              mem_dout,
    output logic [1:0]                        state_leds
);

    localparam int IDX_W = $clog2(NUM_CLIENTS);

    arb_state_t             state_reg;
    logic [IDX_W-1:0]       rr_ptr_reg;
    logic [IDX_W-1:0]       win_idx_reg;
    logic                   win_we_reg;
    logic [ADDR_WIDTH-1:0]  win_addr_reg;
    logic [MEM_WIDTH-1:0]   win_din_reg;
    logic [NUM_CLIENTS-1:0] gnt_reg;
    logic                   mem_we_reg;

    logic [NUM_CLIENTS-1:0] arb_onehot;
    logic [IDX_W-1:0]       arb_idx;
    logic                   arb_any;

    logic [ADDR_WIDTH-1:0]  client_addr [NUM_CLIENTS];
    logic [MEM_WIDTH-1:0]   client_din  [NUM_CLIENTS];

    genvar gi;
    generate
        for (gi = 0; gi < NUM_CLIENTS; gi++) begin : g_unpack
            assign client_addr[gi] = req_addr[gi*ADDR_WIDTH +: ADDR_WIDTH];
            assign client_din[gi]  = req_din[gi*MEM_WIDTH +: MEM_WIDTH];
        end
    endgenerate

    rr_arbiter #(
        .NUM_CLIENTS (NUM_CLIENTS)
    ) u_rr_arbiter (
        .req        (req),
        .rr_ptr     (rr_ptr_reg),
        .gnt_onehot (arb_onehot),
        .gnt_idx    (arb_idx),
        .gnt_any    (arb_any)
    );

    // Access FSM: latches the winner in IDLE and registers the memory-port
    // and grant outputs for the following state.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg    <= IDLE;
            rr_ptr_reg   <= '0;
            win_idx_reg  <= '0;
            win_we_reg   <= 1'b0;
            win_addr_reg <= '0;
            win_din_reg  <= '0;
            gnt_reg      <= '0;
            mem_we_reg   <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (arb_any) begin
                        win_idx_reg  <= arb_idx;
                        win_we_reg   <= req_we[arb_idx];
                        win_addr_reg <= client_addr[arb_idx];
                        win_din_reg  <= client_din[arb_idx];
                        gnt_reg      <= arb_onehot;
                        mem_we_reg   <= req_we[arb_idx];
                        state_reg    <= ISSUE;
                    end
                end
                ISSUE: begin
                    gnt_reg    <= '0;
                    mem_we_reg <= 1'b0;
`ifndef MEM_ARB_FIXED_PRIO_EN
                    rr_ptr_reg <= (win_idx_reg == IDX_W'(NUM_CLIENTS - 1))
                                  ? '0 : win_idx_reg + 1'b1;
`endif
                    state_reg  <= win_we_reg ? IDLE : RESP;
                end
                RESP: begin
                    state_reg <= IDLE;
                end
                default: begin
                    gnt_reg    <= '0;
                    mem_we_reg <= 1'b0;
                    state_reg  <= IDLE;
                end
            endcase
        end
    end

    // Read response: memory data arrives during RESP; reset suppresses it so
    // an aborted read never signals valid.
    always_comb begin
        rd_valid = '0;
        rd_data  = '0;
        if (state_reg == RESP && !rst) begin
            rd_valid[win_idx_reg] = 1'b1;
            rd_data               = mem_dout;
        end
    end

    assign gnt        = gnt_reg;
    assign mem_we     = mem_we_reg;
    assign mem_addr   = win_addr_reg;
    assign mem_din    = win_din_reg;
    assign state_leds = 2'(state_reg);

endmodule : mem_port_arbiter
